// File: rtl/pipe_stage_hs_reg.sv
// EX/MEM pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
// Optional back-pressure counter enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_hs_reg #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 4,
    parameter int WEN_W  = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WEN_W-1:0]  wEnMem_in,
    input  logic [WEN_W-1:0]  wEnReg_in,
    input  logic [RD_W-1:0]   rd_in,
    input  logic              memoryMuxSel_in,
    input  logic              readModeMem_in,
    input  logic [DATA_W-1:0] aluRes_in,
    input  logic [DATA_W-1:0] regData2_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WEN_W-1:0]  wEnMem_out,
    output logic [WEN_W-1:0]  wEnReg_out,
    output logic [RD_W-1:0]   rd_out,
    output logic              memoryMuxSel_out,
    output logic              readModeMem_out,
    output logic [DATA_W-1:0] aluRes_out,
    output logic [DATA_W-1:0] regData2_out
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    typedef struct packed {
        logic [WEN_W-1:0]  wen_mem;
        logic [WEN_W-1:0]  wen_reg;
        logic [RD_W-1:0]   rd;
        logic              mem_mux_sel;
        logic              read_mode_mem;
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] reg_data2;
    } entry_t;

    entry_t in_e;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_vld_q, main_vld_d;
    logic   skid_vld_q, skid_vld_d;
    logic   in_ready_q, in_ready_d;
    logic   accept, pop;

    assign in_e = '{wen_mem:       wEnMem_in,
                    wen_reg:       wEnReg_in,
                    rd:            rd_in,
                    mem_mux_sel:   memoryMuxSel_in,
                    read_mode_mem: readModeMem_in,
                    alu_res:       aluRes_in,
                    reg_data2:     regData2_in};

    assign accept = in_valid & in_ready_q;
    assign pop    = main_vld_q & out_ready;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            // Payload is kept so rd/aluRes/regData2 keep showing the last entry.
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else begin
            case ({main_vld_q, skid_vld_q})
                2'b00: begin
                    if (accept) begin
                        main_d     = in_e;
                        main_vld_d = 1'b1;
                    end
                end
                2'b10: begin
                    if (accept && pop) begin
                        main_d = in_e;
                    end else if (pop) begin
                        main_vld_d = 1'b0;
                    end else if (accept) begin
                        skid_d     = in_e;
                        skid_vld_d = 1'b1;
                    end
                end
                2'b11: begin
                    if (pop) begin
                        main_d     = skid_q;
                        skid_vld_d = 1'b0;
                    end
                end
                default: begin
                    // {0,1} cannot be reached; fall back to EMPTY.
                    main_vld_d = 1'b0;
                    skid_vld_d = 1'b0;
                end
            endcase
        end
        in_ready_d = ~skid_vld_d;
    end

    // in_ready resets low and rises on the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready         = in_ready_q;
    assign out_valid        = main_vld_q;
    assign wEnMem_out       = main_vld_q ? main_q.wen_mem : '0;
    assign wEnReg_out       = main_vld_q ? main_q.wen_reg : '0;
    assign memoryMuxSel_out = main_vld_q & main_q.mem_mux_sel;
    assign readModeMem_out  = main_vld_q & main_q.read_mode_mem;
    assign rd_out           = main_q.rd;
    assign aluRes_out       = main_q.alu_res;
    assign regData2_out     = main_q.reg_data2;

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_vld_q && !out_ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Only reset clears the counter; flush leaves it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    localparam int cnt_w_unused = CNT_W;
`endif

endmodule
